// File: rtl/keypad_scanner_pkg.sv
// keypad_scanner_pkg: key indices, operator codes, scanner state encoding and
// the row/column -> key decode helpers shared by the keypad scanner.
package keypad_scanner_pkg;

   typedef logic [4:0] key_t;

   localparam key_t KEY_0    = 5'd0;
   localparam key_t KEY_1    = 5'd1;
   localparam key_t KEY_2    = 5'd2;
   localparam key_t KEY_3    = 5'd3;
   localparam key_t KEY_4    = 5'd4;
   localparam key_t KEY_5    = 5'd5;
   localparam key_t KEY_6    = 5'd6;
   localparam key_t KEY_7    = 5'd7;
   localparam key_t KEY_8    = 5'd8;
   localparam key_t KEY_9    = 5'd9;
   localparam key_t KEY_ADD  = 5'd10;
   localparam key_t KEY_SUB  = 5'd11;
   localparam key_t KEY_MUL  = 5'd12;
   localparam key_t KEY_DIV  = 5'd13;
   localparam key_t KEY_EQ   = 5'd14;
   localparam key_t KEY_CLR  = 5'd15;
   localparam key_t KEY_BKSP = 5'd16;
   localparam key_t KEY_MS   = 5'd17;
   localparam key_t KEY_MR   = 5'd18;
   localparam key_t KEY_MC   = 5'd19;

   localparam logic [1:0] OP_ADD = 2'd0;
   localparam logic [1:0] OP_SUB = 2'd1;
   localparam logic [1:0] OP_MUL = 2'd2;
   localparam logic [1:0] OP_DIV = 2'd3;

   typedef enum logic [1:0] {
      ST_SCAN,
      ST_DEBOUNCE,
      ST_PRESSED
   } state_e;

   typedef struct packed {
      logic mc;
      logic mr;
      logic ms;
      logic bksp;
      logic clr;
      logic ex;
      logic op;
      logic dig;
   } pulses_t;

   function automatic key_t keymap(input logic [1:0] row, input logic [2:0] col);
      key_t k;
      k = KEY_0;
      case (row)
         2'd0: case (col)
            3'd0: k = KEY_1;
            3'd1: k = KEY_2;
            3'd2: k = KEY_3;
            3'd3: k = KEY_ADD;
            default: k = KEY_MC;
         endcase
         2'd1: case (col)
            3'd0: k = KEY_4;
            3'd1: k = KEY_5;
            3'd2: k = KEY_6;
            3'd3: k = KEY_SUB;
            default: k = KEY_MR;
         endcase
         2'd2: case (col)
            3'd0: k = KEY_7;
            3'd1: k = KEY_8;
            3'd2: k = KEY_9;
            3'd3: k = KEY_MUL;
            default: k = KEY_MS;
         endcase
         default: case (col)
            3'd0: k = KEY_CLR;
            3'd1: k = KEY_0;
            3'd2: k = KEY_EQ;
            3'd3: k = KEY_DIV;
            default: k = KEY_BKSP;
         endcase
      endcase
      return k;
   endfunction

   function automatic logic key_is_digit(input key_t k);
      return k <= KEY_9;
   endfunction

   function automatic logic key_is_op(input key_t k);
      return (k >= KEY_ADD) && (k <= KEY_DIV);
   endfunction

   function automatic logic key_repeats(input key_t k);
      return key_is_digit(k) || (k == KEY_BKSP);
   endfunction

   function automatic logic [1:0] key_op_code(input key_t k);
      logic [1:0] op;
      case (k)
         KEY_SUB: op = OP_SUB;
         KEY_MUL: op = OP_MUL;
         KEY_DIV: op = OP_DIV;
         default: op = OP_ADD;
      endcase
      return op;
   endfunction

   function automatic pulses_t key_pulses(input key_t k);
      pulses_t p;
      p = '0;
      if (key_is_digit(k))   p.dig = 1'b1;
      else if (key_is_op(k)) p.op  = 1'b1;
      else begin
         case (k)
            KEY_EQ:   p.ex   = 1'b1;
            KEY_CLR:  p.clr  = 1'b1;
            KEY_BKSP: p.bksp = 1'b1;
            KEY_MS:   p.ms   = 1'b1;
            KEY_MR:   p.mr   = 1'b1;
            default:  p.mc   = 1'b1;
         endcase
      end
      return p;
   endfunction

   function automatic logic [2:0] col_index(input logic [4:0] coln);
      logic [2:0] idx;
      idx = '0;
      for (int unsigned i = 0; i < 5; i++) begin
         if (!coln[i]) idx = 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: keypad matrix lines plus the key-class pulses and their
// digit/operator payload; master = scanner, slave = keypad/consumer side.
interface keypad_scanner_if;
   logic [3:0] row_n;
   logic [4:0] col_n;
   logic       dig_in;
   logic       op_in;
   logic       ex_in;
   logic       reset_in;
   logic       bksp_in;
   logic       MS_in;
   logic       MR_in;
   logic       MC_in;
   logic [3:0] digit;
   logic [1:0] op_code;

   modport master (
      input  row_n,
      output col_n, dig_in, op_in, ex_in, reset_in, bksp_in,
             MS_in, MR_in, MC_in, digit, op_code
   );

   modport slave (
      output row_n,
      input  col_n, dig_in, op_in, ex_in, reset_in, bksp_in,
             MS_in, MR_in, MC_in, digit, op_code
   );
endinterface

// File: rtl/keypad_scanner_sync.sv
// keypad_sync: two-flop synchroniser for asynchronous inputs; resets to the
// idle (pulled-up) level so no phantom key is seen after reset.
module keypad_sync #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);
   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         meta_q <= '1;
         sync_q <= '1;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x5 keypad column scan, press/release debounce and key-class
// decode. Auto-repeat of digit/BKSP keys is built when KEYPAD_AUTOREPEAT_EN is defined.
module keypad_scanner
   import keypad_scanner_pkg::*;
#(
   parameter int unsigned SCAN_DIV     = 1000,
   parameter int unsigned DEBOUNCE_CNT = 8
`ifdef KEYPAD_AUTOREPEAT_EN
   ,
   parameter int unsigned REPEAT_DELAY = 64,
   parameter int unsigned REPEAT_RATE  = 16
`endif
) (
   input  logic             clock,
   input  logic             reset,
   keypad_scanner_if.master kp
);
   localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned CNT_W = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

   state_e           state_q;
   logic [4:0]       coln_q;
   logic [1:0]       row_q;
   logic [DIV_W-1:0] div_q;
   logic [CNT_W-1:0] cnt_q;
   pulses_t          pls_q;
   logic [3:0]       digit_q;
   logic [1:0]       op_q;

   logic [3:0] rows_s;
   logic [3:0] low;
   logic [1:0] row_enc;
   logic [1:0] row_sel;
   logic [2:0] col_idx;
   logic       sample;
   logic       one_low;
   logic       all_high;
   logic       same_row;
   logic       cnt_done;
   logic       accept;
   logic       fire;
   logic       rep_fire;
   key_t       fire_key;

   keypad_sync #(.WIDTH(4)) u_sync (
      .clk_i (clock),
      .rst_i (reset),
      .d_i   (kp.row_n),
      .q_o   (rows_s)
   );

   always_comb begin
      low      = ~rows_s;
      sample   = (div_q == DIV_LAST);
      one_low  = $onehot(low);
      all_high = (low == '0);
      row_enc  = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         if (low[i]) row_enc = 2'(i);
      end
      same_row = one_low && (row_enc == row_q);
      cnt_done = (32'(cnt_q) + 32'd1) >= DEBOUNCE_CNT;
      col_idx  = col_index(coln_q);
      row_sel  = (state_q == ST_SCAN) ? row_enc : row_q;
      fire_key = keymap(row_sel, col_idx);
      // A single debounce sample is enough to accept straight from SCAN
      accept   = sample && (((state_q == ST_SCAN) && one_low && (DEBOUNCE_CNT <= 1)) ||
                            ((state_q == ST_DEBOUNCE) && same_row && cnt_done));
      fire     = accept || rep_fire;
   end

`ifdef KEYPAD_AUTOREPEAT_EN
   localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int unsigned REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;

   logic [REP_W-1:0] rep_q;
   logic             rep_first_q;
   logic             rep_stop_q;
   logic             rep_due;

   always_comb begin
      rep_due  = (32'(rep_q) + 32'd1) >= (rep_first_q ? REPEAT_DELAY : REPEAT_RATE);
      rep_fire = sample && (state_q == ST_PRESSED) && !all_high && !rep_stop_q &&
                 key_repeats(fire_key) && rep_due;
   end

   // The first all-open sample of a release ends repeating for this press
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rep_q       <= '0;
         rep_first_q <= 1'b1;
         rep_stop_q  <= 1'b0;
      end else if (sample) begin
         if (state_q != ST_PRESSED) begin
            rep_q       <= '0;
            rep_first_q <= 1'b1;
            rep_stop_q  <= 1'b0;
         end else if (all_high) begin
            rep_stop_q  <= 1'b1;
         end else if (!rep_stop_q) begin
            if (rep_fire) begin
               rep_q       <= '0;
               rep_first_q <= 1'b0;
            end else begin
               rep_q <= rep_q + 1'b1;
            end
         end
      end
   end
`else
   assign rep_fire = 1'b0;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_SCAN;
         coln_q  <= 5'b11110;
         row_q   <= '0;
         div_q   <= '0;
         cnt_q   <= '0;
         pls_q   <= '0;
         digit_q <= '0;
         op_q    <= OP_ADD;
      end else begin
         div_q <= (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
         pls_q <= fire ? key_pulses(fire_key) : '0;
         if (fire && key_is_digit(fire_key)) digit_q <= fire_key[3:0];
         if (fire && key_is_op(fire_key))    op_q    <= key_op_code(fire_key);
         if (sample) begin
            unique case (state_q)
               ST_SCAN, ST_DEBOUNCE: begin
                  if (accept) begin
                     state_q <= ST_PRESSED;
                     row_q   <= row_sel;
                     cnt_q   <= '0;
                  end else if ((state_q == ST_SCAN) && one_low) begin
                     state_q <= ST_DEBOUNCE;
                     row_q   <= row_enc;
                     cnt_q   <= CNT_W'(1);
                  end else if ((state_q == ST_DEBOUNCE) && same_row) begin
                     cnt_q <= cnt_q + 1'b1;
                  end else begin
                     state_q <= ST_SCAN;
                     coln_q  <= {coln_q[3:0], coln_q[4]};
                     cnt_q   <= '0;
                  end
               end
               ST_PRESSED: begin
                  if (all_high) begin
                     if (cnt_done) begin
                        state_q <= ST_SCAN;
                        coln_q  <= {coln_q[3:0], coln_q[4]};
                        cnt_q   <= '0;
                     end else begin
                        cnt_q <= cnt_q + 1'b1;
                     end
                  end else begin
                     cnt_q <= '0;
                  end
               end
               default: state_q <= ST_SCAN;
            endcase
         end
      end
   end

   assign kp.col_n    = coln_q;
   assign kp.dig_in   = pls_q.dig;
   assign kp.op_in    = pls_q.op;
   assign kp.ex_in    = pls_q.ex;
   assign kp.reset_in = pls_q.clr;
   assign kp.bksp_in  = pls_q.bksp;
   assign kp.MS_in    = pls_q.ms;
   assign kp.MR_in    = pls_q.mr;
   assign kp.MC_in    = pls_q.mc;
   assign kp.digit    = digit_q;
   assign kp.op_code  = op_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed and random key activity on a modelled 4x5 matrix,
// compared every cycle against a sample-level behavioural model of the scanner.
module tb_keypad_scanner;
   localparam int SD = 4;
   localparam int DB = 3;
   localparam int RD = 8;
   localparam int RR = 4;

   logic             clk;
   logic             rst;
   logic [3:0][4:0]  held;
   logic [3:0]       rown;

   keypad_scanner_if kif ();

   keypad_scanner #(
      .SCAN_DIV     (SD),
      .DEBOUNCE_CNT (DB)
`ifdef KEYPAD_AUTOREPEAT_EN
      ,
      .REPEAT_DELAY (RD),
      .REPEAT_RATE  (RR)
`endif
   ) dut (
      .clock (clk),
      .reset (rst),
      .kp    (kif)
   );

   always #5 clk = ~clk;

   // keypad: a held key shorts its row to the driven (low) column
   always_comb begin
      rown = '1;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 5; c++)
            if (held[r][c] && !kif.col_n[c]) rown[r] = 1'b0;
   end
   assign kif.row_n = rown;

   int checks = 0;
   int errors = 0;

   // key codes: 0-9 digits, 10..13 + - * /, 14 '=', 15 C, 16 BKSP, 17 MS, 18 MR, 19 MC
   int km [4][5] = '{'{1, 2, 3, 10, 19}, '{4, 5, 6, 11, 18}, '{7, 8, 9, 12, 17}, '{15, 0, 14, 13, 16}};

   int m_col, m_phase, m_mode, m_cnt, m_rel, m_row;
   int m_rep_on, m_since, m_first;
   logic [3:0] m_snap;
   int e_code, e_digit, e_op;
   int n_dig, n_op, n_ex, n_clr, n_bksp, n_ms, n_mr, n_mc;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] cls(input int code);
      logic [7:0] v;
      v = '0;
      if (code >= 0 && code <= 9) v[0] = 1'b1;
      else if (code >= 10 && code <= 13) v[1] = 1'b1;
      else if (code >= 14) v[code - 12] = 1'b1;
      return v;
   endfunction

   function automatic logic [3:0] keys_at(input int col);
      logic [3:0] p;
      for (int r = 0; r < 4; r++) p[r] = held[r][col];
      return p;
   endfunction

   task automatic model_reset();
      m_col = 0; m_phase = 0; m_mode = 0; m_cnt = 0; m_rel = 0; m_row = 0;
      m_rep_on = 0; m_since = 0; m_first = 1; m_snap = '0;
      e_code = -1; e_digit = 0; e_op = 0;
   endtask

   task automatic model_fire(input int code);
      e_code = code;
      if (code <= 9) e_digit = code;
      else if (code <= 13) e_op = code - 10;
   endtask

   task automatic model_accept();
      m_mode = 2; m_rel = 0; m_rep_on = 1; m_since = 0; m_first = 1;
      model_fire(km[m_row][m_col]);
   endtask

   task automatic model_sample(input logic [3:0] p);
      int code;
      code = km[m_row][m_col];
      if (m_mode == 0) begin
         if ($countones(p) == 1) begin
            for (int r = 0; r < 4; r++) if (p[r]) m_row = r;
            m_cnt = 1;
            if (m_cnt >= DB) model_accept(); else m_mode = 1;
         end else m_col = (m_col + 1) % 5;
      end else if (m_mode == 1) begin
         if (p == 4'(1 << m_row)) begin
            m_cnt++;
            if (m_cnt >= DB) model_accept();
         end else begin
            m_mode = 0; m_col = (m_col + 1) % 5;
         end
      end else begin
         if (p == 0) begin
            m_rep_on = 0; m_rel++;
            if (m_rel >= DB) begin m_mode = 0; m_col = (m_col + 1) % 5; end
         end else begin
            m_rel = 0;
`ifdef KEYPAD_AUTOREPEAT_EN
            if (m_rep_on != 0 && (code <= 9 || code == 16)) begin
               m_since++;
               if (m_since == (m_first != 0 ? RD : RR)) begin
                  model_fire(code); m_since = 0; m_first = 0;
               end
            end
`endif
         end
      end
   endtask

   task automatic monitor();
      logic [7:0] pv;
      forever begin
         @(negedge clk);
         if (rst) model_reset();
         pv = {kif.MC_in, kif.MR_in, kif.MS_in, kif.bksp_in, kif.reset_in, kif.ex_in, kif.op_in, kif.dig_in};
         chk("col_n", kif.col_n, 5'(~(5'b1 << m_col)));
         chk("pulses", pv, cls(e_code));
         chk("digit", kif.digit, e_digit);
         chk("op_code", kif.op_code, e_op);
         n_dig += kif.dig_in; n_op += kif.op_in; n_ex += kif.ex_in; n_clr += kif.reset_in;
         n_bksp += kif.bksp_in; n_ms += kif.MS_in; n_mr += kif.MR_in; n_mc += kif.MC_in;
         if (!rst) begin
            e_code = -1;
            if (m_phase == 1) m_snap = keys_at(m_col);
            if (m_phase == SD - 1) model_sample(m_snap);
            m_phase = (m_phase + 1) % SD;
         end
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic wait_mode(input int mode, input int limit, input string name);
      int k;
      k = 0;
      while (m_mode != mode && k < limit) begin @(posedge clk); #1; k++; end
      if (m_mode != mode) begin
         checks++; errors++;
         $display("FAIL %s: timeout after %0d cycles, model mode %0d required %0d", name, limit, m_mode, mode);
      end
   endtask

   task automatic total_pulses(output int t);
      t = n_dig + n_op + n_ex + n_clr + n_bksp + n_ms + n_mr + n_mc;
   endtask

   initial begin
      logic [4:0] seq [5];
      logic [3:0][4:0] save;
      int t0, t1, k;
      seq[0] = 5'b11110; seq[1] = 5'b11101; seq[2] = 5'b11011; seq[3] = 5'b10111; seq[4] = 5'b01111;
      clk = 1'b0; rst = 1'b1; held = '0;
      n_dig = 0; n_op = 0; n_ex = 0; n_clr = 0; n_bksp = 0; n_ms = 0; n_mr = 0; n_mc = 0;
      model_reset();
      fork monitor(); join_none

      repeat (3) @(posedge clk);
      #1;
      chk("reset_col_n", kif.col_n, 5'b11110);
      chk("reset_digit", kif.digit, 0);
      chk("reset_op_code", kif.op_code, 0);
      chk("reset_dig_in", kif.dig_in, 0);
      rst = 1'b0;

      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         chk("scan_seq", kif.col_n, seq[(i / 4) % 5]);
      end
      total_pulses(t0);
      chk("idle_pulses", t0, 0);
      wait_cycles(1);

      t0 = n_dig;
      held[1][1] = 1'b1;
      wait_cycles(40);
      held[1][1] = 1'b0;
      wait_cycles(100);
      chk("key5_count", n_dig - t0, 1);
      chk("key5_digit", kif.digit, 5);

      t0 = n_op;
      held[3][3] = 1'b1;
      wait_mode(1, 100, "div_debounce_wait");
      held[3][3] = 1'b0;
      wait_cycles(4);
      held[3][3] = 1'b1;
      chk("div_bounce_nopulse", n_op - t0, 0);
      wait_cycles(60);
      held[3][3] = 1'b0;
      wait_cycles(100);
      chk("div_count", n_op - t0, 1);
      chk("div_op_code", kif.op_code, 3);

      t0 = n_dig;
      held[0][0] = 1'b1;
      k = 0;
      while (n_dig == t0 && k < 200) begin wait_cycles(1); k++; end
      chk("key1_accept", n_dig - t0, 1);
      held[2][2] = 1'b1;
      wait_cycles(40);
      chk("key1_blocks9", n_dig - t0, 1);
      chk("key1_digit", kif.digit, 1);
      held[0][0] = 1'b0;
      wait_cycles(120);
      chk("key9_after_release", n_dig - t0, 2);
      chk("key9_digit", kif.digit, 9);
      held[2][2] = 1'b0;
      wait_cycles(100);

      t0 = n_ex;
      held[3][2] = 1'b1;
      wait_mode(1, 100, "eq_debounce_wait");
      rst = 1'b1;
      #1;
      chk("midreset_col_n", kif.col_n, 5'b11110);
      wait_cycles(3);
      chk("midreset_nopulse", n_ex - t0, 0);
      rst = 1'b0;
      wait_cycles(80);
      chk("eq_after_reset", n_ex - t0, 1);
      held[3][2] = 1'b0;
      wait_cycles(100);

`ifdef KEYPAD_AUTOREPEAT_EN
      t0 = n_bksp;
      held[3][4] = 1'b1;
      wait_cycles(100 * SD);
      held[3][4] = 1'b0;
      wait_cycles(100);
      t1 = n_bksp - t0;
      chk("bksp_repeat_range", int'(t1 >= 22 && t1 <= 25), 1);
      t0 = n_ms;
      held[2][4] = 1'b1;
      wait_cycles(100 * SD);
      held[2][4] = 1'b0;
      wait_cycles(100);
      chk("ms_no_repeat", n_ms - t0, 1);
`endif

      for (int it = 0; it < 40; it++) begin
         held[$urandom_range(0, 3)][$urandom_range(0, 4)] = 1'b1;
         if ($urandom_range(0, 3) == 0) held[$urandom_range(0, 3)][$urandom_range(0, 4)] = 1'b1;
         wait_cycles($urandom_range(4, 40));
         if ($urandom_range(0, 2) == 0) begin
            save = held;
            held = '0;
            wait_cycles($urandom_range(1, 6));
            held = save;
         end
         if ($urandom_range(0, 14) == 0) begin
            rst = 1'b1;
            wait_cycles($urandom_range(1, 3));
            rst = 1'b0;
         end
         wait_cycles($urandom_range(4, 40));
         held = '0;
         wait_cycles($urandom_range(0, 60));
      end
      wait_cycles(100);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
